// File: rtl/bc_out_port_pkg.sv
// Shared definitions for the Basic Computer output port and its future input-port peer.
package bc_out_port_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int BC_DEFAULT_CLKS_PER_BIT = 16;

    // Serial line level for a given frame phase.
    function automatic logic tx_level(input state_t s, input logic [7:0] d, input logic [2:0] idx);
        logic v;
        case (s)
            S_START: v = 1'b0;
            S_DATA:  v = d[idx];
            default: v = 1'b1;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bc_out_port_baud_gen.sv
// Bit-period timer: pulses tick on the last clock of every CLKS_PER_BIT period while enabled.
module bc_baud_gen
    import bc_out_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = BC_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [11:0] LP_LAST = 12'(CLKS_PER_BIT - 1);

    logic [11:0] r_cnt;
    logic        w_tick;

    assign w_tick = en && (r_cnt == LP_LAST);
    assign tick   = w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 12'd0;
        end else if (!en) begin
            r_cnt <= 12'd0;
        end else if (w_tick) begin
            r_cnt <= 12'd0;
        end else begin
            r_cnt <= r_cnt + 12'd1;
        end
    end

endmodule

// File: rtl/bc_out_port.sv
// Basic Computer output device: OUT loads OUTR, the byte goes out as an 8N1 frame on tx,
// and FGO returns high once the stop bit has fully left the line.
module bc_out_port
    import bc_out_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = BC_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       outr_ld,
    input  logic [7:0] ac_in,
    output logic       FGO,
    output logic [7:0] OUTR,
    output logic       tx,
    output logic       busy,
    output logic       ovr
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_outr;
    logic        r_fgo;
    logic        r_ovr;
    logic        r_tx;
    logic [2:0]  r_bit_idx;
    logic        r_stop_done;
    logic        w_tick;
    logic        w_accept;
    logic        w_baud_en;
    logic        w_tx_next;
    logic        w_busy;

    assign w_accept  = outr_ld && r_fgo;
    // tx lags the state by one clock, so STOP holds one extra cycle for the line to finish.
    assign w_baud_en = (r_state != S_IDLE) && !r_stop_done;

    bc_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (w_baud_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next = S_DATA;
                end else begin
                    w_next = S_START;
                end
            end
            S_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
                    w_next = S_STOP;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_STOP: begin
                if (r_stop_done) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_STOP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_tx_next = tx_level(r_state, r_outr, r_bit_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outr      <= 8'h00;
            r_fgo       <= 1'b1;
            r_ovr       <= 1'b0;
            r_tx        <= 1'b1;
            r_bit_idx   <= 3'd0;
            r_stop_done <= 1'b0;
        end else begin
            r_tx        <= w_tx_next;
            r_stop_done <= (r_state == S_STOP) && w_tick;
            if (w_accept) begin
                r_outr    <= ac_in;
                r_fgo     <= 1'b0;
                r_bit_idx <= 3'd0;
            end else begin
                if ((r_state == S_STOP) && r_stop_done) begin
                    r_fgo <= 1'b1;
                end
                if ((r_state == S_DATA) && w_tick) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end
            // A load while the flag is low (including the edge it is being set) is dropped.
            if (outr_ld && !r_fgo) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign FGO  = r_fgo;
    assign OUTR = r_outr;
    assign tx   = r_tx;
    assign busy = w_busy;
    assign ovr  = r_ovr;

endmodule

// File: tb/tb_bc_out_port.sv
// Scoreboarded bench: stimulus queues expected bytes, a line receiver decodes tx and compares.
module tb_bc_out_port;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       outr_ld;
    logic [7:0] ac_in;
    logic       FGO;
    logic [7:0] OUTR;
    logic       tx;
    logic       busy;
    logic       ovr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    bc_out_port #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .outr_ld (outr_ld),
        .ac_in   (ac_in),
        .FGO     (FGO),
        .OUTR    (OUTR),
        .tx      (tx),
        .busy    (busy),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Line receiver: samples each bit mid-period, abandons a frame cut by reset.
    initial begin : monitor
        logic [9:0] bits;
        logic [7:0] rx;
        logic       aborted;
        int         wait_n;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                start_q.push_back(cyc);
                aborted = 1'b0;
                bits    = 10'd0;
                for (int k = 0; k < 10; k++) begin
                    wait_n = (k == 0) ? (C / 2) : C;
                    for (int j = 0; j < wait_n; j++) begin
                        @(negedge clk);
                        if (rst !== 1'b0) aborted = 1'b1;
                    end
                    if (aborted) break;
                    bits[k] = tx;
                end
                if (!aborted) begin
                    rx = bits[8:1];
                    chk("start_bit", {31'd0, bits[0]}, 32'd0);
                    chk("stop_bit", {31'd0, bits[9]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got %0h want none", rx);
                    end else begin
                        chk("frame_byte", {24'd0, rx}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic load(input logic [7:0] b, output int lc);
        @(negedge clk);
        outr_ld = 1'b1;
        ac_in   = b;
        @(posedge clk);
        #1;
        lc      = cyc;
        outr_ld = 1'b0;
        ac_in   = 8'hEE;
    endtask

    task automatic wait_fgo(input int lc, output int d);
        int mism;
        d    = -1;
        mism = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (FGO !== ~busy) mism++;
            if (FGO === 1'b1) begin
                d = cyc - lc;
                break;
            end
        end
        chk("fgo_vs_busy", mism, 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int lc;
        int lc2;
        int d;
        int n;
        rst     = 1'b1;
        outr_ld = 1'b0;
        ac_in   = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_fgo", {31'd0, FGO}, 32'd1);
        chk("rst_outr", {24'd0, OUTR}, 32'h00);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovr", {31'd0, ovr}, 32'd0);

        // Basic frame and flag latency
        exp_q.push_back(8'hA5);
        load(8'hA5, lc);
        chk("a5_fgo_low", {31'd0, FGO}, 32'd0);
        chk("a5_busy", {31'd0, busy}, 32'd1);
        chk("a5_outr", {24'd0, OUTR}, 32'hA5);
        wait_fgo(lc, d);
        chk("a5_fgo_latency", d, 32'd41);

        // Overrun mid-frame
        exp_q.push_back(8'hA5);
        load(8'hA5, lc);
        repeat (10) @(posedge clk);
        load(8'h3C, lc2);
        chk("ovr_outr_kept", {24'd0, OUTR}, 32'hA5);
        chk("ovr_set", {31'd0, ovr}, 32'd1);
        chk("ovr_fgo_low", {31'd0, FGO}, 32'd0);
        wait_fgo(lc, d);
        chk("ovr_fgo_latency", d, 32'd41);
        chk("ovr_sticky", {31'd0, ovr}, 32'd1);
        chk("ovr_outr_end", {24'd0, OUTR}, 32'hA5);
        pulse_rst();
        chk("ovr_cleared", {31'd0, ovr}, 32'd0);

        // Back-to-back frames, then a load on the exact edge FGO rises
        start_q.delete();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        load(8'h55, lc);
        wait_fgo(lc, d);
        chk("b2b_fgo_latency", d, 32'd41);
        outr_ld = 1'b1;
        ac_in   = 8'h0F;
        @(posedge clk);
        #1;
        lc2     = cyc;
        outr_ld = 1'b0;
        ac_in   = 8'hEE;
        chk("b2b_accept", {31'd0, FGO}, 32'd0);
        chk("b2b_no_ovr", {31'd0, ovr}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        outr_ld = 1'b1;
        ac_in   = 8'h3C;
        @(posedge clk);
        #1;
        outr_ld = 1'b0;
        ac_in   = 8'hEE;
        chk("edge_fgo_up", {31'd0, FGO}, 32'd1);
        chk("edge_ovr", {31'd0, ovr}, 32'd1);
        chk("edge_busy", {31'd0, busy}, 32'd0);
        chk("edge_outr", {24'd0, OUTR}, 32'h0F);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        chk("edge_no_frame", n, 32'd0);
        chk("b2b_starts", start_q.size(), 32'd2);
        if (start_q.size() == 2) begin
            chk("b2b_gap", start_q[1] - start_q[0], 32'd42);
        end else begin
            chk("b2b_gap", 32'hFFFFFFFF, 32'd42);
        end

        // Reset during data bit 3 of FF, then a clean frame
        pulse_rst();
        load(8'hFF, lc);
        repeat (4 * C + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_fgo", {31'd0, FGO}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(8'h01);
        load(8'h01, lc);
        wait_fgo(lc, d);
        chk("post_abort_latency", d, 32'd41);

        // Reset in the start bit: full reset state, line stays quiet
        load(8'h99, lc);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_fgo", {31'd0, FGO}, 32'd1);
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_ovr", {31'd0, ovr}, 32'd0);
        chk("mid_rst_outr", {24'd0, OUTR}, 32'h00);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) n++;
        end
        chk("mid_rst_quiet", n, 32'd0);

        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
